// File: rtl/jtag_data_register.sv
// Parametrised JTAG test data register: capture, shift and update stages with a runtime
// one-bit bypass path and a saturating shift-length counter that can gate updates.
module jtag_data_register #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter bit               STRICT_LENGTH = 1'b1,
  localparam int unsigned     CW            = $clog2(WIDTH + 2)
) (
  input  logic             ClockDR,
  input  logic             Reset,
  input  logic             TDI,
  input  logic             Select,
  input  logic             Bypass,
  input  logic             CaptureDR,
  input  logic             ShiftDR,
  input  logic             UpdateDR,
  input  logic [WIDTH-1:0] CaptureIn,
  output logic             TDO,
  output logic [WIDTH-1:0] ParallelOut,
  output logic [CW-1:0]    ShiftCount,
  output logic             LengthError
);

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic             bp_q, bp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             lerr_q, lerr_d;
  logic             len_ok;

  // Next-state: capture beats shift beats update; nothing moves while deselected.
  always_comb begin
    sr_d   = sr_q;
    bp_d   = bp_q;
    cnt_d  = cnt_q;
    po_d   = po_q;
    lerr_d = lerr_q;
    len_ok = (cnt_q == CNT_FULL);
    if (Select) begin
      if (CaptureDR) begin
        if (Bypass) bp_d = 1'b0;
        else        sr_d = CaptureIn;
        cnt_d = '0;
      end else if (ShiftDR) begin
        if (Bypass) bp_d = TDI;
        else        sr_d = {TDI, sr_q[WIDTH-1:1]};
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
      end else if (UpdateDR && !Bypass) begin
        if (len_ok || !STRICT_LENGTH) po_d = sr_q;
        lerr_d = ~len_ok;
      end
    end
  end

  always_ff @(posedge ClockDR or posedge Reset) begin
    if (Reset) begin
      sr_q   <= RESET_VALUE;
      bp_q   <= 1'b0;
      cnt_q  <= '0;
      po_q   <= RESET_VALUE;
      lerr_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bp_q   <= bp_d;
      cnt_q  <= cnt_d;
      po_q   <= po_d;
      lerr_q <= lerr_d;
    end
  end

  // Scan-out source follows Bypass directly so a mode switch is visible at once.
  assign TDO         = Bypass ? bp_q : sr_q[0];
  assign ParallelOut = po_q;
  assign ShiftCount  = cnt_q;
  assign LengthError = lerr_q;

endmodule
